// File: rtl/id_inst_squash_reg_if.sv
// Purpose : bundles the fetch-side inputs and decode-side outputs of the
//           IF/ID squash register so that both ends share one port object.
// Ports   : slave modport = the register (consumes fetch, drives decode);
//           master modport = the pipeline environment (drives fetch/redirect).
interface id_inst_squash_reg_if #(
  parameter int XLEN         = 32,
  parameter int NUM_REDIRECT = 3,
  parameter int CNT_W        = 2,
  parameter int STAT_W       = 16
);
  // fetch side
  logic [XLEN-1:0]               if_inst;
  logic [XLEN-1:0]               if_pc;
  logic                          if_valid;
  // hazard / redirect control
  logic                          stall;
  logic [NUM_REDIRECT-1:0]       redirect_req;
  logic [NUM_REDIRECT*CNT_W-1:0] redirect_len;
  // decode side
  logic [XLEN-1:0]               id_inst;
  logic [XLEN-1:0]               id_pc;
  logic                          id_valid;
  logic                          id_bubble;
  logic [CNT_W-1:0]              squash_cnt;
  logic [STAT_W-1:0]             bubble_count;

  modport master (
    output if_inst, if_pc, if_valid, stall, redirect_req, redirect_len,
    input  id_inst, id_pc, id_valid, id_bubble, squash_cnt, bubble_count
  );

  modport slave (
    input  if_inst, if_pc, if_valid, stall, redirect_req, redirect_len,
    output id_inst, id_pc, id_valid, id_bubble, squash_cnt, bubble_count
  );
endinterface

// File: rtl/id_inst_squash_reg.sv
// Purpose : IF/ID pipeline register that turns control-hazard slots into NOP
//           bubbles. Any redirect source kills the incoming fetch and may arm
//           a further run of squashed slots; a saturating counter tallies them.
// Latency : 1 cycle from if_* to id_*; all outputs come straight from flops.
// Backpressure: stall holds every output and freezes the squash run; a
//           redirect still wins over a concurrent stall.
// Ports   : clk, rst (synchronous, active-high); bus = slave side of
//           id_inst_squash_reg_if (if_inst/if_pc/if_valid, stall,
//           redirect_req/redirect_len in; id_inst/id_pc/id_valid/id_bubble,
//           squash_cnt, bubble_count out).
module id_inst_squash_reg #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] NOP_INST     = XLEN'(32'h00000013),
  parameter int              NUM_REDIRECT = 3,
  parameter int              CNT_W        = 2,
  parameter int              STAT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  id_inst_squash_reg_if.slave bus
);

  // What the register does with the slot arriving this edge.
  typedef enum logic [1:0] {
    ACT_LOAD     = 2'd0,  // normal fetch load
    ACT_REDIRECT = 2'd1,  // kill slot, arm a new squash run
    ACT_HOLD     = 2'd2,  // stall: keep everything
    ACT_SQUASH   = 2'd3   // kill slot as part of an armed run
  } action_t;

  action_t           action;

  logic [XLEN-1:0]   inst_q,   inst_d;
  logic [XLEN-1:0]   pc_q,     pc_d;
  logic              valid_q,  valid_d;
  logic              bubble_q, bubble_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [STAT_W-1:0] stat_q,   stat_d;

  logic [CNT_W-1:0]  max_len;
  logic              redirect;

  // Longest requested extra-squash length among the asserted sources.
  // Lengths of idle sources are ignored, so stale values on their lanes
  // can never stretch a run.
  always_comb begin
    redirect = |bus.redirect_req;
    max_len  = '0;
    for (int i = 0; i < NUM_REDIRECT; i++) begin
      if (bus.redirect_req[i] &&
          (bus.redirect_len[i*CNT_W +: CNT_W] > max_len)) begin
        max_len = bus.redirect_len[i*CNT_W +: CNT_W];
      end
    end
  end

  // Slot arbitration: redirect > stall > pending squash > normal load.
  always_comb begin
    action = ACT_LOAD;
    if (redirect) begin
      action = ACT_REDIRECT;
    end else if (bus.stall) begin
      action = ACT_HOLD;
    end else if (cnt_q != '0) begin
      action = ACT_SQUASH;
    end
  end

  // Next-state for the pipeline payload and squash counter.
  always_comb begin
    inst_d   = inst_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    bubble_d = bubble_q;
    cnt_d    = cnt_q;
    unique case (action)
      ACT_REDIRECT: begin
        inst_d   = NOP_INST;
        pc_d     = bus.if_pc;
        valid_d  = 1'b0;
        bubble_d = 1'b1;
        // A fresh redirect replaces any residual run rather than adding to it.
        cnt_d    = max_len;
      end
      ACT_SQUASH: begin
        inst_d   = NOP_INST;
        pc_d     = bus.if_pc;
        valid_d  = 1'b0;
        bubble_d = 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
      end
      ACT_LOAD: begin
        inst_d   = bus.if_valid ? bus.if_inst : NOP_INST;
        pc_d     = bus.if_pc;
        valid_d  = bus.if_valid;
        bubble_d = ~bus.if_valid;
      end
      ACT_HOLD: begin
        // everything keeps its value, including the squash run length
      end
      default: begin
      end
    endcase
  end

  // Bubble statistics: only slots killed by a redirect or an armed run count.
  // Empty fetches (if_valid=0) are not control-hazard bubbles.
  always_comb begin
    stat_d = stat_q;
    if (((action == ACT_REDIRECT) || (action == ACT_SQUASH)) && !(&stat_q)) begin
      stat_d = stat_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q   <= NOP_INST;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      bubble_q <= 1'b1;
      cnt_q    <= '0;
      stat_q   <= '0;
    end else begin
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
      stat_q   <= stat_d;
    end
  end

  assign bus.id_inst      = inst_q;
  assign bus.id_pc        = pc_q;
  assign bus.id_valid     = valid_q;
  assign bus.id_bubble    = bubble_q;
  assign bus.squash_cnt   = cnt_q;
  assign bus.bubble_count = stat_q;

endmodule

// File: tb/tb_id_inst_squash_reg.sv
// Bench for id_inst_squash_reg: directed vector table, a saturation
// sequence on a narrow-statistics instance, and a random run against a
// behavioural model. Two instances share the stimulus: STAT_W=16 and STAT_W=2.
module tb_id_inst_squash_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus
  logic [31:0] t_inst, t_pc;
  logic        t_valid, t_stall;
  logic [2:0]  t_req;
  logic [5:0]  t_len;

  id_inst_squash_reg_if #(.XLEN(32), .NUM_REDIRECT(3), .CNT_W(2), .STAT_W(16)) bus ();
  id_inst_squash_reg_if #(.XLEN(32), .NUM_REDIRECT(3), .CNT_W(2), .STAT_W(2))  sbus ();

  assign bus.if_inst       = t_inst;
  assign bus.if_pc         = t_pc;
  assign bus.if_valid      = t_valid;
  assign bus.stall         = t_stall;
  assign bus.redirect_req  = t_req;
  assign bus.redirect_len  = t_len;
  assign sbus.if_inst      = t_inst;
  assign sbus.if_pc        = t_pc;
  assign sbus.if_valid     = t_valid;
  assign sbus.stall        = t_stall;
  assign sbus.redirect_req = t_req;
  assign sbus.redirect_len = t_len;

  id_inst_squash_reg #(.XLEN(32), .NOP_INST(32'h00000013), .NUM_REDIRECT(3),
                       .CNT_W(2), .STAT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  id_inst_squash_reg #(.XLEN(32), .NOP_INST(32'h00000013), .NUM_REDIRECT(3),
                       .CNT_W(2), .STAT_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(sbus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drive one cycle of stimulus, let the edge happen, settle 1 time unit.
  task automatic step(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                      input logic v, input logic s, input logic [2:0] req,
                      input logic [5:0] len);
    rst = r; t_inst = inst; t_pc = pc; t_valid = v; t_stall = s;
    t_req = req; t_len = len;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] inst, pc;
    logic        v, s;
    logic [2:0]  req;
    logic [5:0]  len;   // {len2, len1, len0}
    logic [31:0] e_inst, e_pc;
    logic        e_v, e_b;
    logic [1:0]  e_cnt;
    logic [15:0] e_bc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                              input logic v, input logic s, input logic [2:0] req,
                              input logic [5:0] len, input logic [31:0] e_inst,
                              input logic [31:0] e_pc, input logic e_v, input logic e_b,
                              input logic [1:0] e_cnt, input logic [15:0] e_bc);
    vec_t x;
    x.rst = r; x.inst = inst; x.pc = pc; x.v = v; x.s = s; x.req = req; x.len = len;
    x.e_inst = e_inst; x.e_pc = e_pc; x.e_v = e_v; x.e_b = e_b; x.e_cnt = e_cnt; x.e_bc = e_bc;
    return x;
  endfunction

  vec_t tbl[29];

  // behavioural model state (plain integers, bubble total is unbounded)
  logic [31:0] m_inst, m_pc;
  logic        m_valid, m_bub;
  int          m_left;
  int          m_total;

  task automatic model(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                       input logic v, input logic s, input logic [2:0] req,
                       input logic [5:0] len);
    int lens[3];
    int longest;
    for (int k = 0; k < 3; k++) lens[k] = (int'(len) >> (2 * k)) % 4;
    longest = 0;
    for (int k = 0; k < 3; k++) if (req[k] && lens[k] > longest) longest = lens[k];
    if (r) begin
      m_inst = NOP; m_pc = 0; m_valid = 0; m_bub = 1; m_left = 0; m_total = 0;
    end else if (req != 0) begin
      m_inst = NOP; m_pc = pc; m_valid = 0; m_bub = 1; m_left = longest; m_total++;
    end else if (s) begin
      // decode sees the same slot again
    end else if (m_left > 0) begin
      m_inst = NOP; m_pc = pc; m_valid = 0; m_bub = 1; m_left--; m_total++;
    end else begin
      m_inst = v ? inst : NOP; m_pc = pc; m_valid = v; m_bub = !v;
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 32'h0,        32'h0,   0, 0, 3'b000, 6'b000000, NOP,          32'h0,   0, 1, 0, 0);
    tbl[1]  = mk(1, 32'h0,        32'h0,   0, 0, 3'b000, 6'b000000, NOP,          32'h0,   0, 1, 0, 0);
    tbl[2]  = mk(0, 32'h00A00093, 32'h100, 1, 0, 3'b000, 6'b000000, 32'h00A00093, 32'h100, 1, 0, 0, 0);
    tbl[3]  = mk(0, 32'hDEADBEEF, 32'h104, 0, 0, 3'b000, 6'b000000, NOP,          32'h104, 0, 1, 0, 0);
    tbl[4]  = mk(0, 32'h11111111, 32'h108, 1, 0, 3'b001, 6'b000000, NOP,          32'h108, 0, 1, 0, 1);
    tbl[5]  = mk(0, 32'h22222222, 32'h10C, 1, 0, 3'b000, 6'b000000, 32'h22222222, 32'h10C, 1, 0, 0, 1);
    tbl[6]  = mk(0, 32'h2A,       32'h110, 1, 0, 3'b001, 6'b000010, NOP,          32'h110, 0, 1, 2, 2);
    tbl[7]  = mk(0, 32'h33,       32'h114, 1, 0, 3'b000, 6'b000000, NOP,          32'h114, 0, 1, 1, 3);
    tbl[8]  = mk(0, 32'h44,       32'h118, 1, 0, 3'b000, 6'b000000, NOP,          32'h118, 0, 1, 0, 4);
    tbl[9]  = mk(0, 32'h55,       32'h11C, 1, 0, 3'b000, 6'b000000, 32'h55,       32'h11C, 1, 0, 0, 4);
    tbl[10] = mk(0, 32'h5A,       32'h120, 1, 0, 3'b001, 6'b000010, NOP,          32'h120, 0, 1, 2, 5);
    tbl[11] = mk(0, 32'h66,       32'h124, 1, 1, 3'b000, 6'b000000, NOP,          32'h120, 0, 1, 2, 5);
    tbl[12] = mk(0, 32'h66,       32'h124, 1, 1, 3'b000, 6'b000000, NOP,          32'h120, 0, 1, 2, 5);
    tbl[13] = mk(0, 32'h77,       32'h128, 1, 0, 3'b000, 6'b000000, NOP,          32'h128, 0, 1, 1, 6);
    tbl[14] = mk(0, 32'h88,       32'h12C, 1, 0, 3'b000, 6'b000000, NOP,          32'h12C, 0, 1, 0, 7);
    tbl[15] = mk(0, 32'h99,       32'h130, 1, 0, 3'b000, 6'b000000, 32'h99,       32'h130, 1, 0, 0, 7);
    tbl[16] = mk(0, 32'hAA,       32'h134, 1, 1, 3'b000, 6'b000000, 32'h99,       32'h130, 1, 0, 0, 7);
    tbl[17] = mk(0, 32'hAB,       32'h138, 1, 1, 3'b010, 6'b000100, NOP,          32'h138, 0, 1, 1, 8);
    tbl[18] = mk(0, 32'hBB,       32'h13C, 1, 0, 3'b000, 6'b000000, NOP,          32'h13C, 0, 1, 0, 9);
    tbl[19] = mk(0, 32'hBC,       32'h140, 1, 0, 3'b101, 6'b110001, NOP,          32'h140, 0, 1, 3, 10);
    tbl[20] = mk(0, 32'hBD,       32'h144, 1, 0, 3'b000, 6'b000000, NOP,          32'h144, 0, 1, 2, 11);
    tbl[21] = mk(0, 32'hBE,       32'h148, 1, 0, 3'b100, 6'b000000, NOP,          32'h148, 0, 1, 0, 12);
    tbl[22] = mk(0, 32'hCC,       32'h14C, 1, 0, 3'b000, 6'b000000, 32'hCC,       32'h14C, 1, 0, 0, 12);
    tbl[23] = mk(0, 32'hCD,       32'h150, 1, 0, 3'b001, 6'b111101, NOP,          32'h150, 0, 1, 1, 13);
    tbl[24] = mk(0, 32'hDD,       32'h154, 1, 0, 3'b000, 6'b000000, NOP,          32'h154, 0, 1, 0, 14);
    tbl[25] = mk(0, 32'hEE,       32'h158, 1, 0, 3'b000, 6'b000000, 32'hEE,       32'h158, 1, 0, 0, 14);
    tbl[26] = mk(0, 32'hEF,       32'h15C, 1, 0, 3'b010, 6'b001000, NOP,          32'h15C, 0, 1, 2, 15);
    tbl[27] = mk(1, 32'hFF,       32'h160, 1, 1, 3'b001, 6'b000011, NOP,          32'h0,   0, 1, 0, 0);
    tbl[28] = mk(0, 32'h12,       32'h164, 1, 0, 3'b000, 6'b000000, 32'h12,       32'h164, 1, 0, 0, 0);

    // directed vectors
    for (int i = 0; i < 29; i++) begin
      step(tbl[i].rst, tbl[i].inst, tbl[i].pc, tbl[i].v, tbl[i].s, tbl[i].req, tbl[i].len);
      chk($sformatf("vec%0d id_inst", i),    bus.id_inst,           tbl[i].e_inst);
      chk($sformatf("vec%0d id_pc", i),      bus.id_pc,             tbl[i].e_pc);
      chk($sformatf("vec%0d id_valid", i),   32'(bus.id_valid),     32'(tbl[i].e_v));
      chk($sformatf("vec%0d id_bubble", i),  32'(bus.id_bubble),    32'(tbl[i].e_b));
      chk($sformatf("vec%0d squash_cnt", i), 32'(bus.squash_cnt),   32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d bubble_count", i), 32'(bus.bubble_count), 32'(tbl[i].e_bc));
      chk($sformatf("vec%0d sat_count", i),  32'(sbus.bubble_count),
          (tbl[i].e_bc > 16'd3) ? 32'd3 : 32'(tbl[i].e_bc));
    end

    // five back-to-back redirects: narrow counter sticks at all-ones
    for (int i = 0; i < 5; i++) begin
      step(0, 32'h300 + 32'(i), 32'h200 + 32'(4 * i), 1, 0, 3'b001, 6'b000000);
      chk($sformatf("sat%0d bubble_count", i), 32'(bus.bubble_count), 32'(i + 1));
      chk($sformatf("sat%0d sat_count", i),    32'(sbus.bubble_count), (i >= 2) ? 32'd3 : 32'(i + 1));
      chk($sformatf("sat%0d id_bubble", i),    32'(bus.id_bubble), 32'd1);
    end

    // reset asserted in the middle of a long squash run
    step(0, 32'h400, 32'h300, 1, 0, 3'b100, 6'b100000);
    chk("midrst armed cnt", 32'(bus.squash_cnt), 32'd2);
    step(1, 32'h404, 32'h304, 1, 0, 3'b000, 6'b000000);
    chk("midrst cnt",     32'(bus.squash_cnt),   32'd0);
    chk("midrst inst",    bus.id_inst,           NOP);
    chk("midrst pc",      bus.id_pc,             32'd0);
    chk("midrst valid",   32'(bus.id_valid),     32'd0);
    chk("midrst bubble",  32'(bus.id_bubble),    32'd1);
    chk("midrst count",   32'(bus.bubble_count), 32'd0);
    chk("midrst satcnt",  32'(sbus.bubble_count), 32'd0);
    step(0, 32'h408, 32'h308, 1, 0, 3'b000, 6'b000000);
    chk("postrst inst",   bus.id_inst,           32'h408);

    // randomized run against the model
    begin
      logic        r, v, s;
      logic [2:0]  req;
      logic [5:0]  len;
      logic [31:0] inst, pc;
      pc = 32'h1000;
      for (int c = 0; c < 600; c++) begin
        r    = (c == 0) || ($urandom_range(0, 59) == 0);
        req  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        len  = 6'($urandom);
        s    = ($urandom_range(0, 3) == 0);
        v    = ($urandom_range(0, 3) != 0);
        inst = $urandom;
        pc   = pc + 32'd4;
        model(r, inst, pc, v, s, req, len);
        step(r, inst, pc, v, s, req, len);
        chk($sformatf("rnd%0d id_inst", c),    bus.id_inst,           m_inst);
        chk($sformatf("rnd%0d id_pc", c),      bus.id_pc,             m_pc);
        chk($sformatf("rnd%0d id_valid", c),   32'(bus.id_valid),     32'(m_valid));
        chk($sformatf("rnd%0d id_bubble", c),  32'(bus.id_bubble),    32'(m_bub));
        chk($sformatf("rnd%0d squash_cnt", c), 32'(bus.squash_cnt),   32'(m_left));
        chk($sformatf("rnd%0d bubble_count", c), 32'(bus.bubble_count),
            (m_total > 65535) ? 32'd65535 : 32'(m_total));
        chk($sformatf("rnd%0d sat_count", c),  32'(sbus.bubble_count),
            (m_total > 3) ? 32'd3 : 32'(m_total));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
